// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 command frontend: opcodes, FSM states,
// status codes, the 32-bit instruction layout and the permission rule.
package ats21_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_SET_CLOCK = 3'b001,
    OP_ADJ_CLOCK = 3'b010,
    OP_MODE      = 3'b011,
    OP_RSVD      = 3'b100,
    OP_SET_ALARM = 3'b101,
    OP_CLR_ALARM = 3'b110,
    OP_TOGGLE_AT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WORD0 = 2'b01,
    ST_ARB   = 2'b10,
    ST_ISSUE = 2'b11
  } state_e;

  localparam logic [1:0] STAT_IDLE   = 2'b00;
  localparam logic [1:0] STAT_DONE   = 2'b01;
  localparam logic [1:0] STAT_REJECT = 2'b10;
  localparam logic [1:0] STAT_DROP   = 2'b11;

  // word1 = {op, arg}, word0 = val
  typedef struct packed {
    op_e         op;
    logic [12:0] arg;
    logic [15:0] val;
  } instr_t;

  // MODE is always allowed; everything else needs active mode plus the
  // matching per-client permission bit. The reserved opcode never passes.
  function automatic logic op_permitted(input op_e op, input logic active,
                                        input logic at_ok, input logic bc_ok);
    logic ok;
    ok = 1'b0;
    if (op == OP_MODE) begin
      ok = 1'b1;
    end else if (active) begin
      case (op)
        OP_SET_CLOCK, OP_ADJ_CLOCK:               ok = bc_ok;
        OP_SET_ALARM, OP_CLR_ALARM, OP_TOGGLE_AT: ok = at_ok;
        default:                                  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/ats21_rr_arb.sv
// Two-requester round-robin arbiter. A lone requester wins outright; when
// both request, the registered pointer picks the winner and flips only
// when such a contended grant is consumed (advance_i).
module ats21_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_o
);

  logic ptr_q;

  assign gnt_o = (req_i == 2'b11) ? ptr_q : req_i[1];

  // Pointer starts at client A and moves past the winner of each contended grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (advance_i && (req_i == 2'b11)) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/ats21_cmd_frontend.sv
// Two-client instruction frontend for the clock/alarm engine. Captures a
// two-word instruction from both clients, arbitrates between them, applies
// MODE locally, enforces permissions and offers other commands on cmd_*.
//
// Command handshake: cmd_valid rises with a stable payload and both stay
// unchanged until the cycle in which cmd_ready is also high; that cycle is
// the transfer. cmd_ready has no effect while cmd_valid is low.
module ats21_cmd_frontend
  import ats21_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic [1:0]  stat,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_client,
  output logic [2:0]  cmd_op,
  output logic [12:0] cmd_arg,
  output logic [15:0] cmd_val,
  output logic [1:0]  dbg_state
);

  state_e      state_q;
  instr_t      instr_q [2];
  logic [1:0]  pending_q;
  logic        active_q;
  logic [1:0]  at_perm_q;
  logic [1:0]  bc_perm_q;
  logic        cmd_valid_q;
  logic        cmd_client_q;
  logic [2:0]  cmd_op_q;
  logic [12:0] cmd_arg_q;
  logic [15:0] cmd_val_q;

  logic        gnt;
  instr_t      g_instr;
  logic        g_permitted;
  logic        g_mode;
  logic [1:0]  rem_arb;
  logic [1:0]  rem_iss;
  logic        in_arb;
  logic        handshake;

  ats21_rr_arb u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (pending_q),
    .advance_i (in_arb),
    .gnt_o     (gnt)
  );

  assign in_arb     = (state_q == ST_ARB);
  assign handshake  = (state_q == ST_ISSUE) && cmd_valid_q && cmd_ready;
  assign ready      = (state_q == ST_IDLE);
  assign dbg_state  = state_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_client = cmd_client_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_arg    = cmd_arg_q;
  assign cmd_val    = cmd_val_q;

  // Decode the granted instruction and the pending set left after it.
  always_comb begin
    g_instr     = instr_q[gnt];
    g_mode      = (g_instr.op == OP_MODE);
    g_permitted = op_permitted(g_instr.op, active_q, at_perm_q[gnt], bc_perm_q[gnt]);
    rem_arb     = pending_q & (gnt ? 2'b01 : 2'b10);
    rem_iss     = pending_q & (cmd_client_q ? 2'b01 : 2'b10);
  end

  // One-cycle status pulse; a dropped request outranks reject, reject outranks done.
  always_comb begin
    stat = STAT_IDLE;
    if (req && !ready) begin
      stat = STAT_DROP;
    end else if (in_arb && !g_permitted) begin
      stat = STAT_REJECT;
    end else if ((in_arb && g_mode) || handshake) begin
      stat = STAT_DONE;
    end
  end

  // Main FSM: capture, arbitrate/check, issue; owns all frontend state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < 2; i++) instr_q[i] <= '0;
      pending_q    <= 2'b00;
      active_q     <= 1'b1;
      at_perm_q    <= 2'b11;
      bc_perm_q    <= 2'b11;
      cmd_valid_q  <= 1'b0;
      cmd_client_q <= 1'b0;
      cmd_op_q     <= 3'b000;
      cmd_arg_q    <= 13'h0000;
      cmd_val_q    <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            instr_q[0].op  <= op_e'(ctrlA[15:13]);
            instr_q[0].arg <= ctrlA[12:0];
            instr_q[1].op  <= op_e'(ctrlB[15:13]);
            instr_q[1].arg <= ctrlB[12:0];
            state_q        <= ST_WORD0;
          end
        end
        ST_WORD0: begin
          instr_q[0].val <= ctrlA;
          instr_q[1].val <= ctrlB;
          pending_q      <= {instr_q[1].op != OP_NOP, instr_q[0].op != OP_NOP};
          state_q        <= ((instr_q[0].op != OP_NOP) || (instr_q[1].op != OP_NOP))
                            ? ST_ARB : ST_IDLE;
        end
        ST_ARB: begin
          if (g_mode) begin
            active_q  <= g_instr.arg[12];
            at_perm_q <= g_instr.arg[11:10];
            bc_perm_q <= g_instr.arg[9:8];
            pending_q <= rem_arb;
            state_q   <= (rem_arb != 2'b00) ? ST_ARB : ST_IDLE;
          end else if (!g_permitted) begin
            pending_q <= rem_arb;
            state_q   <= (rem_arb != 2'b00) ? ST_ARB : ST_IDLE;
          end else begin
            cmd_valid_q  <= 1'b1;
            cmd_client_q <= gnt;
            cmd_op_q     <= g_instr.op;
            cmd_arg_q    <= g_instr.arg;
            cmd_val_q    <= g_instr.val;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            pending_q   <= rem_iss;
            state_q     <= (rem_iss != 2'b00) ? ST_ARB : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ats21_cmd_frontend.sv
// Directed bench for ats21_cmd_frontend: stimulus pushes expected commands
// and status pulses into queues, a negedge monitor pops and compares them.
module tb_ats21_cmd_frontend;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic        ready;
  logic [1:0]  stat;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_client;
  logic [2:0]  cmd_op;
  logic [12:0] cmd_arg;
  logic [15:0] cmd_val;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_cmd_q[$];
  logic [1:0]  exp_stat_q[$];

  ats21_cmd_frontend dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .ctrlA      (ctrlA),
    .ctrlB      (ctrlB),
    .ready      (ready),
    .stat       (stat),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_client (cmd_client),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_val    (cmd_val),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive word1 in cycle T, word0 in T+1; returns inside cycle T+2.
  task automatic send(input logic [15:0] a1, input logic [15:0] b1,
                      input logic [15:0] a0, input logic [15:0] b0);
    req = 1'b1; ctrlA = a1; ctrlB = b1;
    tick();
    req = 1'b0; ctrlA = a0; ctrlB = b0;
    tick();
    ctrlA = 16'h0000; ctrlB = 16'h0000;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", {63'd0, ready}, 64'd1);
  endtask

  function automatic logic [32:0] mk_cmd(input logic c, input logic [2:0] op,
                                         input logic [12:0] arg, input logic [15:0] val);
    return {c, op, arg, val};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          $display("FAIL cmd_unexpected: got %0h expected none",
                   {cmd_client, cmd_op, cmd_arg, cmd_val});
        end else begin
          chk("cmd_payload", {31'd0, cmd_client, cmd_op, cmd_arg, cmd_val},
              {31'd0, exp_cmd_q.pop_front()});
        end
      end
      if (stat != 2'b00) begin
        if (exp_stat_q.size() == 0) begin
          n_checks++;
          $display("FAIL stat_unexpected: got %0h expected none", stat);
        end else begin
          chk("stat_pulse", {62'd0, stat}, {62'd0, exp_stat_q.pop_front()});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; req = 1'b0; ctrlA = 16'h0000; ctrlB = 16'h0000; cmd_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_ready",     {63'd0, ready}, 64'd1);
    chk("rst_stat",      {62'd0, stat}, 64'd0);
    chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    chk("rst_payload",   {31'd0, cmd_client, cmd_op, cmd_arg, cmd_val}, 64'd0);
    chk("rst_state",     {62'd0, dbg_state}, 64'd0);

    // Single set_clock from A, accepted on the first edge after reset release
    exp_cmd_q.push_back(mk_cmd(1'b0, 3'b001, 13'h0000, 16'h0000));
    exp_stat_q.push_back(2'b01);
    reset_n = 1'b1;
    send(16'h2000, 16'h0000, 16'h0000, 16'h0000);
    chk("single_t2_valid", {63'd0, cmd_valid}, 64'd0);
    chk("single_t2_state", {62'd0, dbg_state}, 64'd2);
    tick();
    chk("single_t3_valid", {63'd0, cmd_valid}, 64'd1);
    chk("single_t3_op",    {61'd0, cmd_op}, 64'd1);
    tick();
    chk("single_t4_ready", {63'd0, ready}, 64'd1);

    // Three contended pairs: pointer A, then B, then A
    for (int p = 0; p < 3; p++) begin
      logic first;
      first = (p == 1);
      if (!first) begin
        exp_cmd_q.push_back(mk_cmd(1'b0, 3'b001, 13'h0000, 16'h0011));
        exp_cmd_q.push_back(mk_cmd(1'b1, 3'b001, 13'h0005, 16'h0022));
      end else begin
        exp_cmd_q.push_back(mk_cmd(1'b1, 3'b001, 13'h0005, 16'h0022));
        exp_cmd_q.push_back(mk_cmd(1'b0, 3'b001, 13'h0000, 16'h0011));
      end
      exp_stat_q.push_back(2'b01);
      exp_stat_q.push_back(2'b01);
      send(16'h2000, 16'h2005, 16'h0011, 16'h0022);
      tick();
      chk("pair_t3_valid",  {63'd0, cmd_valid}, 64'd1);
      chk("pair_t3_client", {63'd0, cmd_client}, {63'd0, first});
      tick();
      chk("pair_t4_gap",    {63'd0, cmd_valid}, 64'd0);
      tick();
      chk("pair_t5_valid",  {63'd0, cmd_valid}, 64'd1);
      chk("pair_t5_client", {63'd0, cmd_client}, {63'd0, ~first});
      tick();
      chk("pair_t6_ready",  {63'd0, ready}, 64'd1);
    end

    // Pointer now at B: B's MODE (active 1, AT=10 -> B only, BC=11) goes
    // first, then A's set_alarm lacks AT permission and is rejected.
    exp_stat_q.push_back(2'b01);
    exp_stat_q.push_back(2'b10);
    send(16'hA017, 16'h7B00, 16'h0025, 16'h0000);
    chk("mode_t2_stat", {62'd0, stat}, 64'd1);
    tick();
    chk("mode_t3_stat", {62'd0, stat}, 64'd2);
    tick();
    chk("mode_t4_ready", {63'd0, ready}, 64'd1);
    chk("mode_t4_valid", {63'd0, cmd_valid}, 64'd0);

    // Inactive mode rejects set_clock; then restore active with full perms
    exp_stat_q.push_back(2'b01);
    send(16'h6F00, 16'h0000, 16'h0000, 16'h0000);
    wait_idle(10);
    exp_stat_q.push_back(2'b10);
    send(16'h2000, 16'h0000, 16'h0000, 16'h0000);
    chk("inactive_reject", {62'd0, stat}, 64'd2);
    wait_idle(10);
    exp_stat_q.push_back(2'b01);
    send(16'h7F00, 16'h0000, 16'h0000, 16'h0000);
    wait_idle(10);

    // Reserved opcode 100 from A: rejected, back in IDLE at T+3
    exp_stat_q.push_back(2'b10);
    send(16'h8000, 16'h0000, 16'h0000, 16'h0000);
    chk("op100_stat",  {62'd0, stat}, 64'd2);
    chk("op100_busy",  {63'd0, ready}, 64'd0);
    tick();
    chk("op100_ready", {63'd0, ready}, 64'd1);

    // Stalled issue with a req pulse during the stall
    cmd_ready = 1'b0;
    exp_cmd_q.push_back(mk_cmd(1'b0, 3'b001, 13'h0005, 16'h1234));
    exp_stat_q.push_back(2'b11);
    exp_stat_q.push_back(2'b01);
    send(16'h2005, 16'h0000, 16'h1234, 16'h0000);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_payload", {30'd0, cmd_valid, cmd_client, cmd_op, cmd_arg, cmd_val},
          {30'd0, 1'b1, mk_cmd(1'b0, 3'b001, 13'h0005, 16'h1234)});
      req   = (i == 3);
      ctrlA = (i == 3) ? 16'hFFFF : 16'h0000;
      tick();
    end
    req = 1'b0; ctrlA = 16'h0000;
    cmd_ready = 1'b1;
    tick();
    chk("stall_done_ready", {63'd0, ready}, 64'd1);

    // Restrict perms (AT=00, BC=10), issue from B, then reset mid-issue
    exp_stat_q.push_back(2'b01);
    send(16'h7200, 16'h0000, 16'h0000, 16'h0000);
    wait_idle(10);
    cmd_ready = 1'b0;
    send(16'h0000, 16'h2005, 16'h0000, 16'hBEEF);
    tick();
    chk("pre_rst_valid",  {63'd0, cmd_valid}, 64'd1);
    chk("pre_rst_client", {63'd0, cmd_client}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, cmd_valid}, 64'd0);
    chk("async_rst_ready", {63'd0, ready}, 64'd1);
    chk("async_rst_op",    {61'd0, cmd_op}, 64'd0);
    tick();
    tick();

    // After reset: A set_clock (BC) and B set_alarm (AT) both allowed, A first
    exp_cmd_q.push_back(mk_cmd(1'b0, 3'b001, 13'h0000, 16'h0001));
    exp_cmd_q.push_back(mk_cmd(1'b1, 3'b101, 13'h0017, 16'h0025));
    exp_stat_q.push_back(2'b01);
    exp_stat_q.push_back(2'b01);
    cmd_ready = 1'b1;
    reset_n = 1'b1;
    send(16'h2000, 16'hA017, 16'h0001, 16'h0025);
    tick();
    chk("post_rst_t3_client", {60'd0, cmd_valid, cmd_client, 2'b00}, {60'd0, 1'b1, 1'b0, 2'b00});
    tick();
    tick();
    chk("post_rst_t5_client", {60'd0, cmd_valid, cmd_client, 2'b00}, {60'd0, 1'b1, 1'b1, 2'b00});
    wait_idle(10);

    repeat (3) tick();
    chk("cmd_queue_drained",  exp_cmd_q.size(), 64'd0);
    chk("stat_queue_drained", exp_stat_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
